// File: rtl/tohost_reporter.sv
// Captures the first passing/failing tohost store after reset and reports the result.
// Define TOHOST_REPORTER_UART_EN to add the 8N1 text report on tx; otherwise done follows capture directly.
module tohost_reporter #(
   parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   output logic        done,
   output logic        passed,
   output logic [30:0] fail_code,
   output logic        busy,
   output logic        tx
);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, FIN} state_t;

   state_t state;
   logic   capture;

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
      $error("tohost_reporter: CLKS_PER_BIT must be within 2..65535");
   end

   assign wr_ready = 1'b1;
   assign capture  = wr_valid && (wr_addr == TOHOST_ADDR) && wr_data[0] && (state == IDLE);

`ifdef TOHOST_REPORTER_UART_EN

   logic [7:0]  shift_reg;
   logic [2:0]  bit_cnt;
   logic [2:0]  byte_idx;
   logic [15:0] baud_cnt;
   logic        baud_last;
   logic [2:0]  last_idx;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] msg_byte(input logic is_pass, input logic [2:0] idx,
                                           input logic [7:0] code);
      logic [7:0] b;
      b = 8'h0A;
      if (is_pass) begin
         case (idx)
            3'd0:       b = 8'h50;
            3'd1:       b = 8'h41;
            3'd2, 3'd3: b = 8'h53;
            default:    b = 8'h0A;
         endcase
      end else begin
         case (idx)
            3'd0:    b = 8'h46;
            3'd1:    b = 8'h41;
            3'd2:    b = 8'h49;
            3'd3:    b = 8'h4C;
            3'd4:    b = 8'h20;
            3'd5:    b = hex_char(code[7:4]);
            3'd6:    b = hex_char(code[3:0]);
            default: b = 8'h0A;
         endcase
      end
      return b;
   endfunction

   assign baud_last = (baud_cnt == 16'(CLKS_PER_BIT - 1));
   assign last_idx  = passed ? 3'd4 : 3'd7;

   // One LOAD cycle per byte plus ten bit periods; tx is registered so it lines up with state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         tx        <= 1'b1;
         done      <= 1'b0;
         passed    <= 1'b0;
         fail_code <= '0;
         busy      <= 1'b0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         byte_idx  <= '0;
         baud_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  passed    <= (wr_data == 32'h1);
                  fail_code <= wr_data[31:1];
                  byte_idx  <= '0;
                  busy      <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               shift_reg <= msg_byte(passed, byte_idx, fail_code[7:0]);
               baud_cnt  <= '0;
               tx        <= 1'b0;
               state     <= START;
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx        <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (byte_idx == last_idx) begin
                     byte_idx <= '0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= FIN;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     state    <= LOAD;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            FIN: begin
               state <= FIN;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`else

   assign tx   = 1'b1;
   assign busy = 1'b0;

   // Without the serialiser the result is reported the moment it is captured.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         done      <= 1'b0;
         passed    <= 1'b0;
         fail_code <= '0;
      end else if (capture) begin
         passed    <= (wr_data == 32'h1);
         fail_code <= wr_data[31:1];
         done      <= 1'b1;
         state     <= FIN;
      end
   end

`endif

endmodule

// File: tb/tb_tohost_reporter.sv
// Bench for tohost_reporter: a message-level model checked every cycle plus literal result pins.
// Follows TOHOST_REPORTER_UART_EN the same way the design does.
module tb_tohost_reporter;

   localparam int C = 4;

   logic        clk;
   logic        rst;
   logic        wr_valid;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        done;
   logic        passed;
   logic [30:0] fail_code;
   logic        busy;
   logic        tx;

   int npass  = 0;
   int ntotal = 0;
   int cyc    = 0;
   int cap_cyc = 0;
   bit chk_en = 0;

   bit          m_cap;
   bit          m_passed;
   logic [30:0] m_code;
   bit          m_done;
   bit          txq[$];
   logic [7:0]  m_msg[$];

   logic [7:0]  rxq[$];
   logic [7:0]  rx_sh;
   bit          rx_act;
   int          rx_cnt;

   tohost_reporter #(.TOHOST_ADDR(32'h0000_1000), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .done(done), .passed(passed), .fail_code(fail_code),
      .busy(busy), .tx(tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
   endfunction

   // The expected message as text, then expanded into one tx level per clock.
   task automatic buildMessage(input logic [31:0] d);
      string s;
      m_msg.delete();
      if (d == 32'h1) s = "PASS";
      else            s = "FAIL ";
      for (int i = 0; i < s.len(); i++) m_msg.push_back(s[i]);
      if (d != 32'h1) begin
         m_msg.push_back(hexc(d[8:5]));
         m_msg.push_back(hexc(d[4:1]));
      end
      m_msg.push_back(8'h0A);
`ifdef TOHOST_REPORTER_UART_EN
      foreach (m_msg[i]) begin
         txq.push_back(1'b1);
         for (int k = 0; k < C; k++) txq.push_back(1'b0);
         for (int b = 0; b < 8; b++)
            for (int k = 0; k < C; k++) txq.push_back(m_msg[i][b]);
         for (int k = 0; k < C; k++) txq.push_back(1'b1);
      end
`endif
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         m_cap = 0; m_passed = 0; m_code = '0; m_done = 0;
         txq.delete();
      end else begin
         if (txq.size() > 0) begin
            txq.delete(0);
            if (txq.size() == 0) m_done = 1;
         end
         if (!m_cap && wr_valid && wr_addr == 32'h0000_1000 && wr_data[0]) begin
            m_cap    = 1;
            m_passed = (wr_data == 32'h1);
            m_code   = wr_data[31:1];
            buildMessage(wr_data);
`ifndef TOHOST_REPORTER_UART_EN
            m_done = 1;
`endif
         end
      end
   end

   // Mid-bit sampling receiver that turns tx back into bytes.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         rx_act = 0;
      end else if (!rx_act) begin
         if (tx === 1'b0) begin
            rx_act = 1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % C == C / 2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
            rx_sh[rx_cnt / C - 1] = tx;
         if (rx_cnt == 9 * C + C / 2) begin
            rxq.push_back(rx_sh);
            rx_act = 0;
         end
      end
   end

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      else
         npass++;
   endtask

   task automatic checkOutput();
      checkValue("done", done, m_done);
      checkValue("passed", passed, m_passed);
      checkValue("fail_code", fail_code, m_code);
      checkValue("busy", busy, (txq.size() > 0));
      checkValue("tx", tx, (txq.size() > 0) ? txq[0] : 1'b1);
      checkValue("wr_ready", wr_ready, 1);
   endtask

   always @(negedge clk) if (chk_en) checkOutput();

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      cap_cyc  = cyc;
      wr_valid = 1'b0; wr_addr = $urandom; wr_data = $urandom;
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst = 1'b0; wr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      rxq.delete();
   endtask

   task automatic waitDone(input int budget, output int lat);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      lat = cyc - cap_cyc;
      checkValue("done_within_budget", done, 1);
   endtask

   task automatic checkBytes(input string name, input logic [7:0] exp[$]);
      checkValue({name, "_count"}, rxq.size(), exp.size());
      foreach (exp[i])
         checkValue(name, (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
   endtask

   logic [7:0] lit_pass[$] = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0A};
   logic [7:0] lit_f03[$]  = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h20, 8'h30, 8'h33, 8'h0A};
   logic [7:0] lit_f55[$]  = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h20, 8'h35, 8'h35, 8'h0A};

   initial begin
      int lat;
      int exp_lat;
      logic [31:0] a, d;
`ifdef TOHOST_REPORTER_UART_EN
      exp_lat = 5 * (10 * C + 1);
`else
      exp_lat = 0;
`endif
      rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1 chk_en = 1;
      @(negedge clk);
      checkValue("reset_done", done, 0);
      checkValue("reset_tx", tx, 1);
      checkValue("reset_busy", busy, 0);
      checkValue("reset_fail_code", fail_code, 0);
      @(posedge clk); #1 rst = 1'b1;

      $display("[TB] wrong address and even data are ignored");
      applyStimulus(32'h0000_1004, 32'h1);
      applyStimulus(32'h0000_1000, 32'h2);
      repeat (10) @(negedge clk);
      checkValue("ignored_done", done, 0);
      checkValue("ignored_tx", tx, 1);

      $display("[TB] pass report with a late store mid-message");
      applyStimulus(32'h0000_1000, 32'h1);
      @(negedge clk);
      checkValue("pass_passed", passed, 1);
      checkValue("pass_fail_code", fail_code, 0);
      if (done !== 1'b1) begin
         repeat (30) @(posedge clk);
         @(posedge clk); #1;
         wr_valid = 1'b1; wr_addr = 32'h0000_1000; wr_data = 32'h15;
         @(posedge clk); #1 wr_valid = 1'b0;
      end
      waitDone(2000, lat);
      checkValue("pass_latency", lat, exp_lat);
      checkValue("pass_sticky", passed, 1);
`ifdef TOHOST_REPORTER_UART_EN
      checkBytes("pass_bytes", lit_pass);
`endif

      $display("[TB] fail report code 3");
      doReset();
      applyStimulus(32'h0000_1000, 32'h0000_0007);
      waitDone(2000, lat);
      checkValue("f03_passed", passed, 0);
      checkValue("f03_fail_code", fail_code, 3);
`ifdef TOHOST_REPORTER_UART_EN
      checkBytes("f03_bytes", lit_f03);
`endif

      $display("[TB] reset wins over a simultaneous capture");
      @(posedge clk); #1;
      rst = 1'b0; wr_valid = 1'b1; wr_addr = 32'h0000_1000; wr_data = 32'h1;
      @(posedge clk); #1;
      rst = 1'b1; wr_valid = 1'b0;
      repeat (5) @(negedge clk);
      checkValue("rst_capture_done", done, 0);
      checkValue("rst_capture_busy", busy, 0);

      $display("[TB] reset mid-message then a fresh report");
      applyStimulus(32'h0000_1000, 32'h1);
      repeat (50) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      checkValue("abort_tx", tx, 1);
      checkValue("abort_done", done, 0);
      checkValue("abort_passed", passed, 0);
      checkValue("abort_busy", busy, 0);
      rxq.delete();
      applyStimulus(32'h0000_1000, 32'h0000_00AB);
      waitDone(2000, lat);
      checkValue("f55_fail_code", fail_code, 31'h55);
`ifdef TOHOST_REPORTER_UART_EN
      checkBytes("f55_bytes", lit_f55);
`endif

      $display("[TB] randomized store sequences");
      for (int it = 0; it < 6; it++) begin
         doReset();
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
               0:       a = 32'h0000_1000;
               1:       a = 32'h0000_1004;
               2:       a = 32'h0000_0FFC;
               default: a = $urandom;
            endcase
            d = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
            applyStimulus(a, d);
            repeat ($urandom_range(0, 20)) @(posedge clk);
         end
         d = ($urandom_range(0, 1) == 0) ? 32'h1 : ($urandom | 32'h1);
         applyStimulus(32'h0000_1000, d);
         waitDone(2000, lat);
`ifdef TOHOST_REPORTER_UART_EN
         checkBytes("random_bytes", m_msg);
`endif
      end

      repeat (3) @(negedge clk);
      chk_en = 0;
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
